// File: rtl/id_stage_hz.sv
// Decode stage with ID/EX register, forwarding-aware operand select, beq/bne
// resolution and a load-use stall FSM that inserts LOAD_LAT bubbles.
module id_stage_hz #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_FWD  = 2,
   parameter int unsigned LOAD_LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                pc_i,
   input  logic [31:0]                inst_i,
   output logic [4:0]                 rf_addr1,
   output logic [4:0]                 rf_addr2,
   input  logic [DATA_W-1:0]          rf_data1,
   input  logic [DATA_W-1:0]          rf_data2,
   input  logic [NUM_FWD-1:0]         fwd_wd,
   input  logic [5*NUM_FWD-1:0]       fwd_addr,
   input  logic [DATA_W*NUM_FWD-1:0]  fwd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [7:0]                 out_aluop,
   output logic [DATA_W-1:0]          out_op1,
   output logic [DATA_W-1:0]          out_op2,
   output logic [4:0]                 out_waddr,
   output logic                       out_wd,
   output logic                       out_mem_rd,
   output logic                       out_mem_wr,
   output logic [DATA_W-1:0]          out_store_data,
   output logic                       out_illegal,
   output logic                       branch_taken,
   output logic [31:0]                branch_target
);

   localparam int unsigned CNT_W = 3;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                          OP_ADDIU = 6'h09, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d,
                          OP_XORI  = 6'h0e, OP_LUI  = 6'h0f, OP_LW   = 6'h23,
                          OP_SW    = 6'h2b;
   localparam logic [5:0] F_SLL  = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                          F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                          F_OR   = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                          F_SLT  = 6'h2a;

   typedef enum logic [0:0] {ST_IDLE, ST_STALL} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;

   logic [5:0]         w_opcode, w_funct;
   logic [4:0]         w_rs, w_rt, w_rd, w_shamt;
   logic [15:0]        w_imm;
   logic [DATA_W-1:0]  w_sext, w_zext, w_rs_val, w_rt_val;

   logic [7:0]         w_aluop;
   logic [DATA_W-1:0]  w_op1, w_op2, w_sd;
   logic [4:0]         w_waddr;
   logic               w_wd, w_mrd, w_mwr, w_ill;
   logic               w_use_rs, w_use_rt, w_is_beq, w_is_bne;
   logic               w_hazard, w_advance, w_issue, w_eq;

   assign w_opcode = inst_i[31:26];
   assign w_rs     = inst_i[25:21];
   assign w_rt     = inst_i[20:16];
   assign w_rd     = inst_i[15:11];
   assign w_shamt  = inst_i[10:6];
   assign w_funct  = inst_i[5:0];
   assign w_imm    = inst_i[15:0];
   assign w_sext   = {{(DATA_W-16){w_imm[15]}}, w_imm};
   assign w_zext   = DATA_W'(w_imm);

   assign rf_addr1 = w_rs;
   assign rf_addr2 = w_rt;

   // Operand resolution: lowest-index forwarding source wins, $0 is hard zero
   always_comb begin
      w_rs_val = (w_rs == 5'd0) ? '0 : rf_data1;
      w_rt_val = (w_rt == 5'd0) ? '0 : rf_data2;
      for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
         if (w_rs != 5'd0 && fwd_wd[i] && fwd_addr[i*5 +: 5] == w_rs)
            w_rs_val = fwd_data[i*DATA_W +: DATA_W];
         if (w_rt != 5'd0 && fwd_wd[i] && fwd_addr[i*5 +: 5] == w_rt)
            w_rt_val = fwd_data[i*DATA_W +: DATA_W];
      end
   end

   // Instruction decode into ID/EX payload; branches and illegal issue as nop
   always_comb begin
      w_aluop  = 8'h00;
      w_op1    = '0;
      w_op2    = '0;
      w_sd     = '0;
      w_waddr  = 5'd0;
      w_wd     = 1'b0;
      w_mrd    = 1'b0;
      w_mwr    = 1'b0;
      w_ill    = 1'b0;
      w_use_rs = 1'b0;
      w_use_rt = 1'b0;
      w_is_beq = 1'b0;
      w_is_bne = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            case (w_funct)
               F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
                  w_use_rs = 1'b1;
                  w_use_rt = 1'b1;
                  w_aluop  = {2'b00, w_funct};
                  w_op1    = w_rs_val;
                  w_op2    = w_rt_val;
                  w_waddr  = w_rd;
                  w_wd     = 1'b1;
               end
               F_SLL, F_SRL, F_SRA: begin
                  w_use_rt = 1'b1;
                  w_aluop  = {2'b00, w_funct};
                  w_op1    = DATA_W'(w_shamt);
                  w_op2    = w_rt_val;
                  w_waddr  = w_rd;
                  w_wd     = 1'b1;
               end
               default: w_ill = 1'b1;
            endcase
         end
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
            w_use_rs = 1'b1;
            w_aluop  = {2'b01, w_opcode};
            w_op1    = w_rs_val;
            w_op2    = (w_opcode == OP_ADDIU || w_opcode == OP_LW) ? w_sext : w_zext;
            w_waddr  = w_rt;
            w_wd     = 1'b1;
            w_mrd    = (w_opcode == OP_LW);
         end
         OP_LUI: begin
            w_aluop = {2'b01, w_opcode};
            w_op2   = DATA_W'({w_imm, 16'h0000});
            w_waddr = w_rt;
            w_wd    = 1'b1;
         end
         OP_SW: begin
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
            w_aluop  = {2'b01, w_opcode};
            w_op1    = w_rs_val;
            w_op2    = w_sext;
            w_sd     = w_rt_val;
            w_mwr    = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_use_rs = 1'b1;
            w_use_rt = 1'b1;
            w_is_beq = (w_opcode == OP_BEQ);
            w_is_bne = (w_opcode == OP_BNE);
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign w_hazard  = in_valid & out_valid & out_mem_rd & (out_waddr != 5'd0) &
                      ((w_use_rs & (w_rs == out_waddr)) | (w_use_rt & (w_rt == out_waddr)));
   assign w_advance = out_ready | ~out_valid;
   assign w_issue   = (r_state == ST_IDLE) & ~w_hazard & in_valid;
   assign w_eq      = (w_rs_val == w_rt_val);

   assign in_ready      = ~rst & (r_state == ST_IDLE) & w_advance & ~w_hazard & in_valid;
   assign branch_taken  = in_ready & in_valid & ((w_is_beq & w_eq) | (w_is_bne & ~w_eq));
   assign branch_target = pc_i + 32'd4 + {{14{w_imm[15]}}, w_imm, 2'b00};

   // ID/EX register and stall FSM; anything not issued loads as an all-zero bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         out_valid      <= 1'b0;
         out_aluop      <= 8'h00;
         out_op1        <= '0;
         out_op2        <= '0;
         out_waddr      <= 5'd0;
         out_wd         <= 1'b0;
         out_mem_rd     <= 1'b0;
         out_mem_wr     <= 1'b0;
         out_store_data <= '0;
         out_illegal    <= 1'b0;
      end else if (w_advance) begin
         out_valid      <= w_issue;
         out_aluop      <= w_issue ? w_aluop : 8'h00;
         out_op1        <= w_issue ? w_op1 : '0;
         out_op2        <= w_issue ? w_op2 : '0;
         out_waddr      <= w_issue ? w_waddr : 5'd0;
         out_wd         <= w_issue & w_wd;
         out_mem_rd     <= w_issue & w_mrd;
         out_mem_wr     <= w_issue & w_mwr;
         out_store_data <= w_issue ? w_sd : '0;
         out_illegal    <= w_issue & w_ill;
         case (r_state)
            ST_IDLE: begin
               if (w_hazard) begin
                  r_cnt   <= CNT_W'(LOAD_LAT - 1);
                  r_state <= (LOAD_LAT > 1) ? ST_STALL : ST_IDLE;
               end
            end
            ST_STALL: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt <= CNT_W'(1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz (LOAD_LAT=2): expected ID/EX contents queued
// per cycle and compared after the clock edge.
module tb_id_stage_hz;

   typedef struct packed {
      logic        valid;
      logic [7:0]  aluop;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  waddr;
      logic        wd;
      logic        mem_rd;
      logic        mem_wr;
      logic [31:0] sd;
      logic        illegal;
   } idex_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] pc_i, inst_i;
   logic [4:0]  rf_addr1, rf_addr2;
   logic [31:0] rf_data1, rf_data2;
   logic [1:0]  fwd_wd;
   logic [9:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic        out_valid, out_ready;
   logic [7:0]  out_aluop;
   logic [31:0] out_op1, out_op2, out_store_data;
   logic [4:0]  out_waddr;
   logic        out_wd, out_mem_rd, out_mem_wr, out_illegal;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic [31:0] rf [32];
   idex_t       sb [$];
   idex_t       obs, last;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      rf_data1 = rf[rf_addr1];
      rf_data2 = rf[rf_addr2];
   end

   assign obs = {out_valid, out_aluop, out_op1, out_op2, out_waddr, out_wd,
                 out_mem_rd, out_mem_wr, out_store_data, out_illegal};

   id_stage_hz #(.DATA_W(32), .NUM_FWD(2), .LOAD_LAT(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .inst_i(inst_i), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
      .rf_data1(rf_data1), .rf_data2(rf_data2), .fwd_wd(fwd_wd),
      .fwd_addr(fwd_addr), .fwd_data(fwd_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_aluop(out_aluop), .out_op1(out_op1),
      .out_op2(out_op2), .out_waddr(out_waddr), .out_wd(out_wd),
      .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_store_data(out_store_data), .out_illegal(out_illegal),
      .branch_taken(branch_taken), .branch_target(branch_target)
   );

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic idex_t mk(input logic v, input logic [7:0] a, input logic [31:0] o1, o2,
                                input logic [4:0] wa, input logic wd, mr, mw,
                                input logic [31:0] sd, input logic il);
      return {v, a, o1, o2, wa, wd, mr, mw, sd, il};
   endfunction

   function automatic idex_t alu(input logic [7:0] a, input logic [31:0] o1, o2, input logic [4:0] wa);
      return mk(1'b1, a, o1, o2, wa, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
   endfunction

   task automatic set_fwd(input int i, input logic wd, input logic [4:0] a, input logic [31:0] d);
      fwd_wd[i]           = wd;
      fwd_addr[i*5 +: 5]  = a;
      fwd_data[i*32 +: 32] = d;
   endtask

   // One clock: queue expected ID/EX, check handshake/branch, then check register
   task automatic cyc(input idex_t e, input logic exp_rdy, input logic exp_tk, input string tag);
      idex_t ex;
      sb.push_back(e);
      last = e;
      #1;
      checks++;
      assert (in_ready === exp_rdy) else begin
         errors++;
         $error("FAIL %s in_ready: got %b expected %b", tag, in_ready, exp_rdy);
      end
      checks++;
      assert (branch_taken === exp_tk) else begin
         errors++;
         $error("FAIL %s branch_taken: got %b expected %b", tag, branch_taken, exp_tk);
      end
      @(posedge clk);
      #1;
      ex = sb.pop_front();
      checks++;
      assert (obs === ex) else begin
         errors++;
         $error("FAIL %s idex: got %h expected %h", tag, obs, ex);
      end
   endtask

   initial begin
      idex_t z, lw4, nop_br;
      logic [31:0] i_addu5;
      z      = '0;
      nop_br = mk(1'b1, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[0] = 32'hdead_beef;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      fwd_wd = '0; fwd_addr = '0; fwd_data = '0;
      out_ready = 1'b1;
      pc_i      = 32'h0;

      // reset: equal-operand beq presented, must not be taken
      rst = 1'b1; in_valid = 1'b1; inst_i = itype(6'h04, 5'd1, 5'd1, 16'h0);
      cyc(z, 1'b0, 1'b0, "rst0");
      cyc(z, 1'b0, 1'b0, "rst1");
      rst = 1'b0;

      inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
      cyc(alu(8'h21, 32'd5, 32'd7, 5'd3), 1'b1, 1'b0, "addu");

      set_fwd(0, 1'b1, 5'd1, 32'hAA); set_fwd(1, 1'b1, 5'd1, 32'hBB);
      inst_i = rtype(5'd1, 5'd0, 5'd6, 5'd0, 6'h21);
      cyc(alu(8'h21, 32'hAA, 32'h0, 5'd6), 1'b1, 1'b0, "fwd_prio");
      set_fwd(0, 1'b1, 5'd0, 32'h55); set_fwd(1, 1'b0, 5'd0, 32'h0);
      inst_i = rtype(5'd0, 5'd2, 5'd7, 5'd0, 6'h25);
      cyc(alu(8'h25, 32'h0, 32'd7, 5'd7), 1'b1, 1'b0, "fwd_r0");
      set_fwd(0, 1'b1, 5'd1, 32'hAA); set_fwd(1, 1'b1, 5'd2, 32'hBB);
      inst_i = rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h21);
      cyc(alu(8'h21, 32'hAA, 32'hBB, 5'd8), 1'b1, 1'b0, "fwd_both");
      set_fwd(0, 1'b0, 5'd0, 32'h0); set_fwd(1, 1'b0, 5'd0, 32'h0);

      inst_i = itype(6'h0d, 5'd1, 5'd9, 16'h8001);
      cyc(alu(8'h4d, 32'd5, 32'h0000_8001, 5'd9), 1'b1, 1'b0, "ori");
      inst_i = itype(6'h09, 5'd1, 5'd10, 16'h8001);
      cyc(alu(8'h49, 32'd5, 32'hffff_8001, 5'd10), 1'b1, 1'b0, "addiu");
      inst_i = itype(6'h0f, 5'd0, 5'd11, 16'h1234);
      cyc(alu(8'h4f, 32'h0, 32'h1234_0000, 5'd11), 1'b1, 1'b0, "lui");
      inst_i = rtype(5'd0, 5'd2, 5'd12, 5'd4, 6'h00);
      cyc(alu(8'h00, 32'd4, 32'd7, 5'd12), 1'b1, 1'b0, "sll");
      inst_i = itype(6'h2b, 5'd1, 5'd2, 16'h0008);
      cyc(mk(1'b1, 8'h6b, 32'd5, 32'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'd7, 1'b0), 1'b1, 1'b0, "sw");

      inst_i = 32'hFC00_0000;
      cyc(mk(1'b1, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b1, 1'b0, "ill_op");
      inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h08);
      cyc(mk(1'b1, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1), 1'b1, 1'b0, "ill_fn");
      in_valid = 1'b0;
      cyc(z, 1'b0, 1'b0, "idle");
      in_valid = 1'b1;

      // branches at pc 0x100, offset -1 -> target 0x100
      rf[1] = 32'd3; rf[2] = 32'd3; pc_i = 32'h100;
      inst_i = itype(6'h04, 5'd1, 5'd2, 16'hffff);
      cyc(nop_br, 1'b1, 1'b1, "beq_t");
      checks++;
      assert (branch_target === 32'h100) else begin
         errors++;
         $error("FAIL br_target: got %h expected %h", branch_target, 32'h100);
      end
      rf[2] = 32'd4;
      cyc(nop_br, 1'b1, 1'b0, "beq_nt");
      inst_i = itype(6'h05, 5'd1, 5'd2, 16'hffff);
      cyc(nop_br, 1'b1, 1'b1, "bne_t");
      set_fwd(0, 1'b1, 5'd2, 32'd3);
      inst_i = itype(6'h04, 5'd1, 5'd2, 16'hffff);
      cyc(nop_br, 1'b1, 1'b1, "beq_fwd");
      set_fwd(0, 1'b0, 5'd0, 32'h0);

      // load-use: two bubbles, then issue with forwarded load result
      lw4     = mk(1'b1, 8'h63, 32'd3, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      i_addu5 = rtype(5'd4, 5'd4, 5'd5, 5'd0, 6'h21);
      inst_i = itype(6'h23, 5'd1, 5'd4, 16'h0);
      cyc(lw4, 1'b1, 1'b0, "lw");
      inst_i = i_addu5;
      cyc(z, 1'b0, 1'b0, "lu_b1");
      cyc(z, 1'b0, 1'b0, "lu_b2");
      set_fwd(0, 1'b1, 5'd4, 32'h77);
      cyc(alu(8'h21, 32'h77, 32'h77, 5'd5), 1'b1, 1'b0, "lu_issue");
      set_fwd(0, 1'b0, 5'd0, 32'h0);

      // hazard takes precedence over an otherwise-taken branch
      inst_i = itype(6'h23, 5'd1, 5'd4, 16'h0);
      cyc(lw4, 1'b1, 1'b0, "lw_b");
      inst_i = itype(6'h04, 5'd4, 5'd4, 16'h0001);
      cyc(z, 1'b0, 1'b0, "brh_b1");
      cyc(z, 1'b0, 1'b0, "brh_b2");
      cyc(nop_br, 1'b1, 1'b1, "brh_go");

      // downstream backpressure holds ID/EX
      inst_i = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
      cyc(alu(8'h21, 32'd3, 32'd4, 5'd3), 1'b1, 1'b0, "pre_hold");
      out_ready = 1'b0;
      inst_i = rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h25);
      cyc(last, 1'b0, 1'b0, "hold1");
      cyc(last, 1'b0, 1'b0, "hold2");
      cyc(last, 1'b0, 1'b0, "hold3");
      out_ready = 1'b1;
      cyc(alu(8'h25, 32'd3, 32'd4, 5'd7), 1'b1, 1'b0, "release");

      // reset during STALL returns to IDLE; next instruction issues at once
      inst_i = itype(6'h23, 5'd1, 5'd4, 16'h0);
      cyc(lw4, 1'b1, 1'b0, "lw_r");
      inst_i = i_addu5;
      cyc(z, 1'b0, 1'b0, "st_b1");
      rst = 1'b1;
      cyc(z, 1'b0, 1'b0, "st_rst");
      rst = 1'b0;
      cyc(alu(8'h21, 32'h0, 32'h0, 5'd5), 1'b1, 1'b0, "post_rst");
      in_valid = 1'b0;
      cyc(z, 1'b0, 1'b0, "drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
